// File: rtl/step_pkg.sv
// Shared step/dir interface constants, so step generators and decoders agree on
// direction encoding and default pulse timing.
package step_pkg;

    localparam logic DIR_TO_MIN    = 1'b1;
    localparam int   DEF_POS_W     = 32;
    localparam int   DEF_MIN_HIGH  = 4;
    localparam int   DEF_MIN_LOW   = 4;
    localparam int   DEF_DIR_SETUP = 2;
    localparam int   DEF_CNT_W     = 8;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus one-cycle rise/fall
// pulses derived from the synchronized value.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver for one axis: tracks signed position, latches homed on
// endstop contact and raises sticky flags for pulse-width, dir-setup and overflow violations.
module step_dir_decoder
    import step_pkg::*;
#(
    parameter int POS_W     = DEF_POS_W,
    parameter int MIN_HIGH  = DEF_MIN_HIGH,
    parameter int MIN_LOW   = DEF_MIN_LOW,
    parameter int DIR_SETUP = DEF_DIR_SETUP,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_in,
    input  logic                    dir_in,
    input  logic                    endstop_min,
    input  logic                    pos_load,
    input  logic signed [POS_W-1:0] pos_load_value,
    input  logic                    clear_err,
    output logic signed [POS_W-1:0] position,
    output logic                    step_strobe,
    output logic                    homed,
    output logic                    err_short_pulse,
    output logic                    err_dir_setup,
    output logic                    err_overflow
);

    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

    logic step_s, step_rise, step_fall;
    logic dir_s, dir_rise, dir_fall;
    logic end_s, end_rise, unused_end_fall;

    sync_edge u_step_sync (.clk(clk), .reset(reset), .d(step_in),
                           .q(step_s), .rise(step_rise), .fall(step_fall));
    sync_edge u_dir_sync  (.clk(clk), .reset(reset), .d(dir_in),
                           .q(dir_s), .rise(dir_rise), .fall(dir_fall));
    sync_edge u_end_sync  (.clk(clk), .reset(reset), .d(endstop_min),
                           .q(end_s), .rise(end_rise), .fall(unused_end_fall));

    logic [CNT_W-1:0] high_cnt, low_cnt, dir_cnt, dir_age;
    logic [1:0]       fill;
    logic             warm, armed, seen_fall;
    logic             step_edge, step_live, blocked, at_limit;
    logic             short_hi, short_lo, dir_viol, ovf_viol;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Steps count only once a genuine low level has been seen since reset, so a
    // line already high at reset release is not mistaken for a fresh edge.
    assign warm      = (fill == 2'd2);
    assign step_edge = step_rise & armed;
    assign step_live = step_edge & ~pos_load & ~end_rise;
    assign dir_age   = (dir_rise | dir_fall) ? '0 : dir_cnt;
    assign blocked   = (dir_s == DIR_TO_MIN) & end_s;
    assign at_limit  = (dir_s == DIR_TO_MIN) ? (position == POS_MIN) : (position == POS_MAX);

    assign short_hi  = step_fall & armed & (high_cnt < CNT_W'(MIN_HIGH));
    assign short_lo  = step_edge & seen_fall & (low_cnt < CNT_W'(MIN_LOW));
    assign dir_viol  = step_live & ~blocked & (dir_age < CNT_W'(DIR_SETUP));
    assign ovf_viol  = step_live & ~blocked & at_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            position        <= '0;
            step_strobe     <= 1'b0;
            homed           <= 1'b0;
            err_short_pulse <= 1'b0;
            err_dir_setup   <= 1'b0;
            err_overflow    <= 1'b0;
            high_cnt        <= '0;
            low_cnt         <= '0;
            dir_cnt         <= '0;
            fill            <= '0;
            armed           <= 1'b0;
            seen_fall       <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            high_cnt    <= step_s ? sat_inc(high_cnt) : '0;
            low_cnt     <= step_s ? '0 : sat_inc(low_cnt);
            dir_cnt     <= sat_inc(dir_age);
            fill        <= warm ? fill : fill + 2'd1;
            armed       <= armed | step_fall | (warm & ~step_s);
            seen_fall   <= seen_fall | step_fall;

            if (pos_load) begin
                position <= pos_load_value;
            end else if (end_rise) begin
                position <= '0;
            end else if (step_live) begin
                if (blocked) begin
                    position <= '0;
                end else if (!at_limit) begin
                    position    <= (dir_s == DIR_TO_MIN) ? position - POS_W'(1)
                                                         : position + POS_W'(1);
                    step_strobe <= 1'b1;
                end
            end

            if (end_rise) begin
                homed <= 1'b1;
            end

            // A violation in the same cycle as clear_err must survive the clear.
            err_short_pulse <= (err_short_pulse & ~clear_err) | short_hi | short_lo;
            err_dir_setup   <= (err_dir_setup & ~clear_err) | dir_viol;
            err_overflow    <= (err_overflow & ~clear_err) | ovf_viol;
        end
    end

endmodule
